// File: rtl/lsu_pkg.sv
// Shared definitions for the multi-cycle load/store unit: op encodings,
// FSM state type and op decode helpers.
package lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'b010000;
    localparam logic [5:0] OP_LH  = 6'b010001;
    localparam logic [5:0] OP_LW  = 6'b010010;
    localparam logic [5:0] OP_LBU = 6'b010100;
    localparam logic [5:0] OP_LHU = 6'b010101;
    localparam logic [5:0] OP_SB  = 6'b110000;
    localparam logic [5:0] OP_SH  = 6'b110001;
    localparam logic [5:0] OP_SW  = 6'b110010;

    typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_e;

    // Access size in bytes; 0 marks an illegal op.
    function automatic logic [2:0] op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            OP_LW, OP_SW:         return 3'd4;
            default:              return 3'd0;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: store mask/data placement across two beats and
// load extraction from a {hi,lo} word pair with sign/zero extension.
module lsu_lane_align (
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic [7:0]  mask8_o,
    output logic [63:0] data64_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  base;
    logic [31:0] win;

    always_comb begin
        base     = (8'd1 << size_i) - 8'd1;
        mask8_o  = base << off_i;
        data64_o = {32'd0, wdata_i} << {off_i, 3'b000};
        win      = 32'({hi_i, lo_i} >> {off_i, 3'b000});
        case (size_i)
            3'd1:    rdata_o = sext_i ? {{24{win[7]}}, win[7:0]}   : {24'd0, win[7:0]};
            3'd2:    rdata_o = sext_i ? {{16{win[15]}}, win[15:0]} : {16'd0, win[15:0]};
            default: rdata_o = win;
        endcase
    end

endmodule

// File: rtl/lsu_split.sv
// Multi-cycle LSU: req/ack DMEM port with wait states, optional timeout,
// and misaligned halfword/word accesses split into two aligned beats.
module lsu_split
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1,
    parameter int TIMEOUT     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              dreq,
    output logic [ADDR_W-1:0] daddr,
    output logic [3:0]        dwe,
    output logic [31:0]       dwdata,
    input  logic              dack,
    input  logic [31:0]       drdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, lo_q, hi_q;
    logic [2:0]        size_q;
    logic              split_q, err_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [2:0]        req_size, req_span;
    logic              req_split, timeout_hit, is_store;
    logic [ADDR_W-3:0] word_nxt;
    logic [7:0]        mask8;
    logic [63:0]       data64;
    logic [31:0]       ld_data;

    lsu_lane_align u_align (
        .size_i  (size_q),
        .off_i   (addr_q[1:0]),
        .sext_i  (op_signed(op_q)),
        .wdata_i (wdata_q),
        .lo_i    (lo_q),
        .hi_i    (hi_q),
        .mask8_o (mask8),
        .data64_o(data64),
        .rdata_o (ld_data)
    );

    always_comb begin
        req_size    = op_size(req_op);
        req_span    = {1'b0, req_addr[1:0]} + req_size;
        req_split   = req_span > 3'd4;
        cnt_d       = cnt_q + CNT_W'(1);
        timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
        is_store    = op_q[5];
        // Second beat wraps to word 0 from the top of the address space.
        word_nxt    = addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1);
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        dreq       = 1'b0;
        daddr      = '0;
        dwe        = 4'd0;
        dwdata     = 32'd0;
        if (state_q == S_ACC0) begin
            dreq   = 1'b1;
            daddr  = {addr_q[ADDR_W-1:2], 2'b00};
            dwe    = is_store ? mask8[3:0] : 4'd0;
            dwdata = is_store ? data64[31:0] : 32'd0;
        end else if (state_q == S_ACC1) begin
            dreq   = 1'b1;
            daddr  = {word_nxt, 2'b00};
            dwe    = is_store ? mask8[7:4] : 4'd0;
            dwdata = is_store ? data64[63:32] : 32'd0;
        end
        resp_valid = (state_q == S_RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !is_store) ? ld_data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            size_q  <= '0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    op_q    <= req_op;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    size_q  <= req_size;
                    split_q <= req_split;
                    lo_q    <= '0;
                    hi_q    <= '0;
                    cnt_q   <= '0;
                    if (req_size == 3'd0 || (req_split && !MISALIGN_EN)) begin
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        err_q   <= 1'b0;
                        state_q <= S_ACC0;
                    end
                end
                S_ACC0: if (dack) begin
                    lo_q    <= drdata;
                    cnt_q   <= '0;
                    state_q <= split_q ? S_ACC1 : S_RESP;
                end else if (timeout_hit) begin
                    err_q   <= 1'b1;
                    state_q <= S_RESP;
                end else begin
                    cnt_q   <= cnt_d;
                end
                S_ACC1: if (dack) begin
                    hi_q    <= drdata;
                    state_q <= S_RESP;
                end else if (timeout_hit) begin
                    // A completed beat-0 store stays written; only beat 1 is dropped.
                    err_q   <= 1'b1;
                    state_q <= S_RESP;
                end else begin
                    cnt_q   <= cnt_d;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_split.md
# lsu_split

Multi-cycle load/store unit for the RV32I core: accepts one load/store request per handshake, drives the DMEM port with a req/ack protocol, and returns sign- or zero-extended load data. Unlike the single-cycle path, it tolerates DMEM wait states and splits misaligned halfword/word accesses into two aligned bus beats. It sits between the control/execute stage, which supplies op, effective address and rs2 data, and the data memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; address arithmetic wraps modulo 2^ADDR_W
- MISALIGN_EN, 1, 1 = split misaligned accesses; 0 = flag them as errors with no bus access
- TIMEOUT, 0, cycles to wait for dack before erroring; 0 = wait forever

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_op  in  6  LB 010000, LH 010001, LW 010010, LBU 010100, LHU 010101, SB 110000, SH 110001, SW 110010
- req_addr  in  ADDR_W  effective byte address
- req_wdata  in  32  store data (rs2), LSB-justified
- dreq  out  1  DMEM beat request
- daddr  out  ADDR_W  word-aligned beat address, bits [1:0] = 0
- dwe  out  4  byte-lane write enables; 0 for loads
- dwdata  out  32  lane-positioned store data
- dack  in  1  DMEM beat complete; drdata valid in the same cycle
- drdata  in  32  DMEM read word
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: illegal op, disallowed misalign, or timeout

## Operation
- States: IDLE, ACC0, ACC1, RESP. Encoding is a registered state; outputs are decoded from the state and captured registers.
- IDLE: req_ready=1. On req_valid, capture op, addr and wdata, then decode size (B=1, H=2, W=4) and off=addr[1:0].
  - Illegal op -> RESP with err.
  - off+size>4 and MISALIGN_EN=0 -> RESP with err. No dreq is raised.
  - Otherwise -> ACC0. split = (off+size>4).
- Lane math: mask8 = ((1<<size)-1)<<off (8 bits). data64 = wdata<<(8*off). Beat 0 uses mask8[3:0] and data64[31:0]. Beat 1 uses mask8[7:4] and data64[63:32].
- ACC0: dreq=1, daddr={addr[ADDR_W-1:2],00}, dwe=mask8[3:0] (stores only). On dack, latch drdata into lo. If split -> ACC1, else -> RESP.
- ACC1: dreq=1, daddr=word address+4 (wraps to 0 from the top word). On dack, latch drdata into hi -> RESP.
- Load result: ({hi,lo}>>8*off), truncated to size. Sign-extended for LB/LH; zero-extended for LBU/LHU/LW.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. Responses have no backpressure.
- Timeout (TIMEOUT>0): the wait counter clears on entry to ACC0 and ACC1 and increments each cycle without dack. When it reaches TIMEOUT, dreq drops, the unit goes to RESP with err=1, rdata=0, and the remaining beat is abandoned. A beat-0 store that already completed is not rolled back.
- dack while dreq=0 is ignored.

## Timing
- Reset: any edge with reset=0 forces state to IDLE and clears all captured registers and the counter. After that edge: req_ready=1; dreq, dwe, daddr, dwdata, resp_valid, resp_rdata and resp_err are all 0.
- Reset mid-access: dreq deasserts after the reset edge. The response is lost.
- Aligned access, dack in the first dreq cycle: accept at cycle 0, dreq at cycle 1, resp_valid at cycle 2.
- Split access: one extra cycle per beat. Each DMEM wait cycle adds one.
- Error without a bus access: resp_valid is asserted the cycle after accept.
- req_ready=0 from ACC0 through RESP. A new request can be accepted on the cycle after resp_valid.
- daddr, dwe and dwdata are stable while dreq=1 and dack=0.

## Structure
- lsu_pkg holds the op encodings, the state enum, and the size/illegal-op decode function. The control unit shares the op constants.
- Sub-module lsu_lane_align is combinational. It computes the mask8/data64 shift for stores, and the {hi,lo} right-shift plus extension for loads. It is reused by a future cache fill path.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, dack immediate -> one beat: daddr 0x100, dwe 1111, dwdata 0xDEADBEEF; resp_valid at cycle 2, err 0.
- LH addr 0x203, word 0x200=0x11223344, word 0x204=0xAABBCCDD, MISALIGN_EN=1 -> two beats at 0x200 then 0x204; resp_rdata 0xFFFFDD11.
- SW addr 0x102, data 0xCAFEF00D -> beat 0: dwe 1100, dwdata 0xF00D0000. Beat 1 at 0x104: dwe 0011, dwdata 0x0000CAFE.
- Same LH at 0x203 with MISALIGN_EN=0 -> no dreq; resp_valid with err=1, rdata 0 the cycle after accept.
- LBU addr 0x7, TIMEOUT=4, dack held low -> dreq for 4 cycles then drops; resp err=1. Repeat with dack after 3 wait cycles -> err 0.
- Assert reset during ACC1 of a split store -> dreq 0 and req_ready 1 after the reset edge; no resp_valid; the next aligned LW completes normally.
